// File: rtl/inc_jno_core.sv
// Tiny accumulator core with INC / JNO / CLR / HALT instructions.
// Two-cycle FETCH/EXEC sequencing over a small writable program memory.
module inc_jno_core #(
  parameter int unsigned DATA_W = 2,
  parameter int unsigned PC_W   = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clock,
  input  logic              Resetter,
  input  logic              start,
  input  logic              prog_we,
  input  logic [PC_W-1:0]   prog_addr,
  input  logic [PC_W+1:0]   prog_data,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] out,
  output logic              status,
  output logic              running,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  localparam int unsigned INSTR_W = PC_W + 2;
  localparam int unsigned DEPTH   = 1 << PC_W;

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_JNO  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALTED} state_t;

  state_t               state;
  logic [INSTR_W-1:0]   mem [DEPTH];
  logic [INSTR_W-1:0]   ir;
  logic                 idle_like;
  logic [DATA_W:0]      inc_sum;
  logic [1:0]           opcode;
  logic [PC_W-1:0]      target;
  logic [PC_W-1:0]      pc_next_seq;
  logic [CNT_W-1:0]     retired_next;

  assign idle_like    = (state == IDLE) || (state == HALTED);
  assign inc_sum      = {1'b0, out} + (DATA_W+1)'(1);
  assign opcode       = ir[PC_W+1:PC_W];
  assign target       = ir[PC_W-1:0];
  assign pc_next_seq  = pc + PC_W'(1);
  assign retired_next = (retired == {CNT_W{1'b1}}) ? retired : retired + CNT_W'(1);

  // Program memory is never reset so a loaded program survives a reset pulse.
  always_ff @(posedge clock) begin
    if (prog_we && idle_like) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Control FSM; running/halted are registered alongside the state they decode.
  always_ff @(posedge clock or posedge Resetter) begin
    if (Resetter) begin
      state   <= IDLE;
      pc      <= '0;
      out     <= '0;
      status  <= 1'b0;
      retired <= '0;
      running <= 1'b0;
      halted  <= 1'b0;
      ir      <= '0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (start) begin
            state   <= FETCH;
            pc      <= '0;
            retired <= '0;
            running <= 1'b1;
            halted  <= 1'b0;
          end
        end
        FETCH: begin
          ir    <= mem[pc];
          state <= EXEC;
        end
        EXEC: begin
          retired <= retired_next;
          case (opcode)
            OP_INC: begin
              out    <= inc_sum[DATA_W-1:0];
              status <= status | inc_sum[DATA_W];
              pc     <= pc_next_seq;
              state  <= FETCH;
            end
            OP_JNO: begin
              pc    <= status ? pc_next_seq : target;
              state <= FETCH;
            end
            OP_CLR: begin
              out    <= '0;
              status <= 1'b0;
              pc     <= pc_next_seq;
              state  <= FETCH;
            end
            default: begin
              state   <= HALTED;
              running <= 1'b0;
              halted  <= 1'b1;
            end
          endcase
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          halted  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/inc_jno_core.md
INC_JNO_CORE -- requirements
Module: inc_jno_core

Interface
REQ-001 SHALL have parameter DATA_W, default 2: accumulator width in bits, minimum 1.
REQ-002 SHALL have parameter PC_W, default 2: program counter width; program depth is 2**PC_W words.
REQ-003 SHALL have parameter CNT_W, default 8: retired-instruction counter width.
REQ-004 SHALL have port clock, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port Resetter, input, 1: asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1: begin execution at PC 0.
REQ-007 SHALL have port prog_we, input, 1: program-memory write strobe.
REQ-008 SHALL have port prog_addr, input, PC_W: program-memory write address.
REQ-009 SHALL have port prog_data, input, 2+PC_W: instruction word; opcode in bits [PC_W+1:PC_W], target in bits [PC_W-1:0].
REQ-010 SHALL have port pc, output, PC_W: current program counter.
REQ-011 SHALL have port out, output, DATA_W: accumulator.
REQ-012 SHALL have port status, output, 1: sticky overflow flag.
REQ-013 SHALL have port running, output, 1: high in FETCH or EXEC.
REQ-014 SHALL have port halted, output, 1: high in HALTED.
REQ-015 SHALL have port retired, output, CNT_W: count of executed instructions.

Function
REQ-016 SHALL implement states IDLE, FETCH, EXEC and HALTED.
REQ-017 IDLE or HALTED, with start=1: SHALL go to FETCH, set pc=0 and clear retired; out and status are retained.
REQ-018 FETCH SHALL latch mem[pc] into an internal instruction register and go to EXEC; each instruction therefore takes exactly 2 cycles.
REQ-019 EXEC with opcode 00 (INC) SHALL apply out<=out+1 modulo 2**DATA_W.
REQ-020 INC SHALL set status<=status|carry-out, then set pc<=pc+1 and go to FETCH.
REQ-021 EXEC with opcode 01 (JNO) SHALL set pc<=target if status=0, else pc<=pc+1, then go to FETCH.
REQ-022 EXEC with opcode 10 (CLR) SHALL clear out and status, set pc<=pc+1 and go to FETCH.
REQ-023 EXEC with opcode 11 (HALT) SHALL leave pc unchanged and go to HALTED.
REQ-024 status SHALL be sticky: once 1, only CLR or reset returns it to 0.
REQ-025 pc+1 SHALL wrap from 2**PC_W-1 to 0.
REQ-026 retired SHALL increment by 1 on every EXEC cycle, including HALT, and SHALL saturate at 2**CNT_W-1.
REQ-027 A prog_we write SHALL take effect only in IDLE or HALTED; writes in FETCH or EXEC SHALL be ignored.
REQ-028 start asserted in FETCH or EXEC SHALL be ignored.
REQ-029 prog_we and start asserted in the same idle cycle: the write SHALL complete, and the following FETCH SHALL read post-write contents if its address equals the written address.
REQ-030 running and halted SHALL be decoded directly from state, registered and glitch-free.

Reset
REQ-031 While Resetter=1, regardless of clock: state=IDLE, pc=0, out=0, status=0, retired=0, running=0, halted=0.
REQ-032 Reset asserted mid-instruction SHALL abort that instruction with no partial update.
REQ-033 Program memory SHALL NOT be reset; its contents are retained across reset.
REQ-034 Leaving reset SHALL NOT start execution; start is required.

Verification
REQ-035 Defaults; program {INC, JNO 0, HALT, HALT}; start -> HALTED after 18 cycles with out=00, status=1, pc=2, retired=9.
REQ-036 Program {INC, HALT, x, x}, start twice -> after the first run out=01; after the second run out=10, retired=2 each run.
REQ-037 Program {INC, INC, INC, INC} with no HALT -> pc wraps 3->0 and execution continues; out wraps 11->00 with status=1.
REQ-038 prog_we to address 0 during EXEC -> memory unchanged; the same write while HALTED takes effect on the next run.
REQ-039 Resetter pulsed during EXEC of INC -> out=0, status=0, state IDLE immediately; program contents intact on restart.
REQ-040 CNT_W=3, looping program run for more than 7 EXEC cycles -> retired holds at 7.
